// File: rtl/load_store_unit_if.sv
// Handshake and memory-bus bundle between the core/memory side and the load/store unit.
// Ports: request (valid/ready + command fields), response (valid/ready + data/error),
//        data memory port (we/address/write data out of the LSU, combinational read data in).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_read_data;
    logic        resp_error;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    // Environment side: the core issuing requests plus the data memory returning read data.
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_address, req_write_data,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_read_data, resp_error,
        input  mem_we, mem_address, mem_write_data
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_address, req_write_data,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_read_data, resp_error,
        output mem_we, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word alignment, sign/zero extension,
//   read-modify-write for sub-word stores, error detection before any memory access.
// Latency accept->resp_valid: 1 cycle error, 2 cycles load/word store, 3 cycles sub-word store.
// Backpressure: req_ready only in IDLE; response held stable in DONE until resp_ready.
// Ports: clock, reset_n (async active-low), bus (load_store_unit_if.slave).
module load_store_unit #(
    parameter int MEM_ADDR_BITS = 16,
    parameter int ALIGN_CHECK   = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    load_store_unit_if.slave       bus
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic [31:0] resp_read_data_q;
    logic        mem_we_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_write_data_q;

    logic        req_err;
    logic [31:0] load_data_d;
    logic [31:0] merge_data_d;
    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_error     = resp_error_q;
    assign bus.resp_read_data = resp_read_data_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;

    // Request is rejected up front so no memory cycle is ever started for it.
    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == SZ_ILL) begin
            req_err = 1'b1;
        end
        if ((bus.req_address >> MEM_ADDR_BITS) != 32'd0) begin
            req_err = 1'b1;
        end
        if (ALIGN_CHECK != 0) begin
            if ((bus.req_size == SZ_HALF) && bus.req_address[0]) begin
                req_err = 1'b1;
            end
            if ((bus.req_size == SZ_WORD) && (bus.req_address[1:0] != 2'b00)) begin
                req_err = 1'b1;
            end
        end
    end

    // Half lanes only look at lane_q[1], so an unaligned half with the check disabled
    // naturally truncates to its aligned half; words ignore the lane entirely.
    assign byte_shifted = bus.mem_read_data >> {lane_q, 3'b000};
    assign half_shifted = bus.mem_read_data >> {lane_q[1], 4'b0000};
    assign byte_mask    = 32'h0000_00FF << {lane_q, 3'b000};
    assign half_mask    = 32'h0000_FFFF << {lane_q[1], 4'b0000};

    always_comb begin
        load_data_d  = bus.mem_read_data;
        merge_data_d = bus.mem_read_data;
        case (size_q)
            SZ_BYTE: begin
                load_data_d  = {{24{~unsigned_q & byte_shifted[7]}}, byte_shifted[7:0]};
                merge_data_d = (bus.mem_read_data & ~byte_mask)
                             | ({24'd0, wdata_q[7:0]} << {lane_q, 3'b000});
            end
            SZ_HALF: begin
                load_data_d  = {{16{~unsigned_q & half_shifted[15]}}, half_shifted[15:0]};
                merge_data_d = (bus.mem_read_data & ~half_mask)
                             | ({16'd0, wdata_q[15:0]} << {lane_q[1], 4'b0000});
            end
            default: begin
                load_data_d  = bus.mem_read_data;
                merge_data_d = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            write_q          <= 1'b0;
            size_q           <= SZ_BYTE;
            unsigned_q       <= 1'b0;
            lane_q           <= 2'b00;
            wdata_q          <= 32'd0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_error_q     <= 1'b0;
            resp_read_data_q <= 32'd0;
            mem_we_q         <= 1'b0;
            mem_address_q    <= 32'd0;
            mem_write_data_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        write_q     <= bus.req_write;
                        size_q      <= bus.req_size;
                        unsigned_q  <= bus.req_unsigned;
                        lane_q      <= bus.req_address[1:0];
                        wdata_q     <= bus.req_write_data;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            resp_valid_q     <= 1'b1;
                            resp_error_q     <= 1'b1;
                            resp_read_data_q <= 32'd0;
                            state_q          <= ST_DONE;
                        end else begin
                            mem_address_q <= {bus.req_address[31:2], 2'b00};
                            // Word stores write during ACCESS itself; set we one edge early
                            // so it is registered for exactly the ACCESS cycle.
                            if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                                mem_we_q         <= 1'b1;
                                mem_write_data_q <= bus.req_write_data;
                            end
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!write_q) begin
                        resp_read_data_q <= load_data_d;
                        resp_valid_q     <= 1'b1;
                        state_q          <= ST_DONE;
                    end else if (size_q == SZ_WORD) begin
                        mem_we_q         <= 1'b0;
                        resp_read_data_q <= 32'd0;
                        resp_valid_q     <= 1'b1;
                        state_q          <= ST_DONE;
                    end else begin
                        mem_we_q         <= 1'b1;
                        mem_write_data_q <= merge_data_d;
                        state_q          <= ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    mem_we_q         <= 1'b0;
                    resp_read_data_q <= 32'd0;
                    resp_valid_q     <= 1'b1;
                    state_q          <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q     <= 1'b0;
                        resp_error_q     <= 1'b0;
                        resp_read_data_q <= 32'd0;
                        req_ready_q      <= 1'b1;
                        state_q          <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_ADDR_BITS(16), .ALIGN_CHECK(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Data memory: combinational read, write on rising edge; backdoor port for preloading.
    logic [31:0] mem [0:16383];
    logic        bd_vld = 1'b0;
    logic [13:0] bd_idx = '0;
    logic [31:0] bd_dat = '0;
    int          we_count = 0;

    assign bus.mem_read_data = mem[bus.mem_address[15:2]];

    always @(posedge clock) begin
        if (bd_vld) mem[bd_idx] <= bd_dat;
        else if (bus.mem_we) mem[bus.mem_address[15:2]] <= bus.mem_write_data;
        if (bus.mem_we) we_count <= we_count + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] dat);
        bd_vld = 1'b1;
        bd_idx = idx[13:0];
        bd_dat = dat;
        @(posedge clock);
        @(negedge clock);
        bd_vld = 1'b0;
    endtask

    // One full transaction; called at a negedge, returns at a negedge with the LSU idle.
    task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic err, output int lat);
        int  guard;
        bit  stable;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (bus.req_ready !== 1'b1) chk("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
        bus.req_write      = wr;
        bus.req_size       = sz;
        bus.req_unsigned   = uns;
        bus.req_address    = addr;
        bus.req_write_data = wd;
        bus.req_valid      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        rd  = bus.resp_read_data;
        err = bus.resp_error;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (bus.resp_valid !== 1'b1 || bus.resp_read_data !== rd ||
                bus.resp_error !== err || bus.req_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", {31'd0, stable}, 32'd1);
        bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.resp_ready = 1'b0;
        if (hold > 0) chk("idle_after_hold", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    endtask

    // Reference model computed directly from the access rules with plain arithmetic.
    function automatic void model(input logic [31:0] word, input bit wr, input logic [1:0] sz,
                                  input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd,
                                  output logic [31:0] nw, output int lat);
        longint unsigned nbytes, off, mask, val, w;
        err = (sz == 2'b11) || (addr >= 32'h0001_0000) ||
              (sz == 2'b01 && (addr % 2) != 0) || (sz == 2'b10 && (addr % 4) != 0);
        rd = 32'd0;
        nw = word;
        if (err) begin
            lat = 1;
            return;
        end
        nbytes = 64'd1 << sz;
        off    = (nbytes == 4) ? 0 : ((addr % 4) / nbytes) * nbytes;
        mask   = (64'd1 << (8 * nbytes)) - 1;
        w      = {32'd0, word};
        if (!wr) begin
            val = (w >> (8 * off)) & mask;
            if (!uns && nbytes < 4 && val >= (mask + 1) / 2) val = val + (64'hFFFF_FFFF - mask);
            rd  = val[31:0];
            lat = 2;
        end else begin
            val = (w & ~(mask << (8 * off))) | (({32'd0, wd} & mask) << (8 * off));
            nw  = val[31:0];
            lat = (nbytes == 4) ? 2 : 3;
        end
    endfunction

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wd;
        int          hold;
        logic        e_err;
        logic [31:0] e_data;
        int          e_lat;
        logic [31:0] e_word;
        int          e_we;
    } vec_t;

    vec_t         tbl [13];
    logic [31:0]  ref_mem [16];

    initial begin
        logic [31:0] rd, nw, e_rd;
        logic        err, e_err;
        int          lat, e_lat, we0;

        bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;  bus.req_address = '0;  bus.req_write_data = '0;
        bus.resp_ready = 1'b0;

        // wr sz uns addr wd hold | err data lat word@0x8 we-pulses
        tbl[0]  = '{0, 2'b00, 1, 32'h9,     32'h0,         0, 0, 32'h0000_007F, 2, 32'h8081_7F01, 0};
        tbl[1]  = '{0, 2'b01, 0, 32'hA,     32'h0,         0, 0, 32'hFFFF_8081, 2, 32'h8081_7F01, 0};
        tbl[2]  = '{0, 2'b00, 0, 32'hB,     32'h0,         0, 0, 32'hFFFF_FF80, 2, 32'h8081_7F01, 0};
        tbl[3]  = '{0, 2'b10, 0, 32'h8,     32'h0,         5, 0, 32'h8081_7F01, 2, 32'h8081_7F01, 0};
        tbl[4]  = '{0, 2'b10, 0, 32'h6,     32'h0,         0, 1, 32'h0,         1, 32'h8081_7F01, 0};
        tbl[5]  = '{1, 2'b00, 0, 32'h9,     32'h0000_00AA, 0, 0, 32'h0,         3, 32'h8081_AA01, 1};
        tbl[6]  = '{1, 2'b01, 0, 32'h8,     32'h1234_BEEF, 0, 0, 32'h0,         3, 32'h8081_BEEF, 1};
        tbl[7]  = '{0, 2'b01, 1, 32'h8,     32'h0,         0, 0, 32'h0000_BEEF, 2, 32'h8081_BEEF, 0};
        tbl[8]  = '{1, 2'b11, 0, 32'h8,     32'h5555_5555, 0, 1, 32'h0,         1, 32'h8081_BEEF, 0};
        tbl[9]  = '{1, 2'b10, 0, 32'h1_0008, 32'h1111_1111, 0, 1, 32'h0,        1, 32'h8081_BEEF, 0};
        tbl[10] = '{1, 2'b01, 0, 32'h9,     32'h2222_2222, 0, 1, 32'h0,         1, 32'h8081_BEEF, 0};
        tbl[11] = '{1, 2'b10, 0, 32'h8,     32'hDEAD_BEEF, 0, 0, 32'h0,         2, 32'hDEAD_BEEF, 1};
        tbl[12] = '{0, 2'b00, 0, 32'h8,     32'h0,         0, 0, 32'hFFFF_FFEF, 2, 32'hDEAD_BEEF, 0};

        @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready",   {31'd0, bus.req_ready},  32'd1);
        chk("rst_resp_valid",  {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_error",  {31'd0, bus.resp_error}, 32'd0);
        chk("rst_resp_data",   bus.resp_read_data,      32'd0);
        chk("rst_mem_we",      {31'd0, bus.mem_we},     32'd0);
        chk("rst_mem_address", bus.mem_address,         32'd0);
        chk("rst_mem_wdata",   bus.mem_write_data,      32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        preload(2, 32'h8081_7F01);
        for (int i = 0; i < 13; i++) begin
            we0 = we_count;
            do_req(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, tbl[i].hold,
                   rd, err, lat);
            chk($sformatf("v%0d_err", i),  {31'd0, err}, {31'd0, tbl[i].e_err});
            chk($sformatf("v%0d_data", i), rd, tbl[i].e_data);
            chk($sformatf("v%0d_lat", i),  lat, tbl[i].e_lat);
            chk($sformatf("v%0d_word", i), mem[2], tbl[i].e_word);
            chk($sformatf("v%0d_we", i),   we_count - we0, tbl[i].e_we);
        end

        // Reset while the merged word is on the bus: the write must never land.
        bus.req_write = 1'b1;  bus.req_size = 2'b00;  bus.req_unsigned = 1'b0;
        bus.req_address = 32'h9;  bus.req_write_data = 32'h55;  bus.req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("merge_we_high", {31'd0, bus.mem_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_mem_we",     {31'd0, bus.mem_we},     32'd0);
        chk("abort_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("abort_mem_addr",   bus.mem_address,         32'd0);
        chk("abort_mem_wdata",  bus.mem_write_data,      32'd0);
        @(posedge clock);
        @(negedge clock);
        chk("abort_word", mem[2], 32'hDEAD_BEEF);
        reset_n = 1'b1;
        @(negedge clock);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 16; i++) begin
            nw = $urandom;
            ref_mem[i] = nw;
            preload(i, nw);
        end
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, d;
            logic [1:0]  s;
            bit          w, u;
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) a = a + 32'h0001_0000;
            s = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            d = $urandom;
            model(ref_mem[a[5:2]], w, s, u, a, d, e_err, e_rd, nw, e_lat);
            ref_mem[a[5:2]] = nw;
            do_req(w, s, u, a, d, $urandom_range(0, 3), rd, err, lat);
            chk($sformatf("r%0d_err", n),  {31'd0, err}, {31'd0, e_err});
            chk($sformatf("r%0d_data", n), rd, e_rd);
            chk($sformatf("r%0d_lat", n),  lat, e_lat);
            chk($sformatf("r%0d_word", n), mem[a[5:2]], ref_mem[a[5:2]]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
